// File: rtl/inter_frame_space_ctrl_if.sv
// Bundle between the frame decoder / transmit arbiter and the CAN interframe-space controller.
// samplePoint is the only qualifier: inputs are meaningful only on a clk where it is high, and the
// result pulses are valid for the single clk that follows that edge. There is no backpressure.
interface inter_frame_space_ctrl_if #(
  parameter int MAX_OVERLOADS = 2
);
  localparam int OVL_W = (MAX_OVERLOADS > 0) ? $clog2(MAX_OVERLOADS + 1) : 1;

  logic             samplePoint;
  logic             canRX;
  logic             frameEnd;
  logic             endIsOverload;
  logic             wasTransmitter;
  logic             errorPassive;

  logic             isOverload;
  logic             isStart;
  logic             isFormError;
  logic             busIdle;
  logic             txAllowed;
  logic [1:0]       ifsState;
  logic [OVL_W-1:0] overloadCount;

  modport master (
    output samplePoint, canRX, frameEnd, endIsOverload, wasTransmitter, errorPassive,
    input  isOverload, isStart, isFormError, busIdle, txAllowed, ifsState, overloadCount
  );

  modport slave (
    input  samplePoint, canRX, frameEnd, endIsOverload, wasTransmitter, errorPassive,
    output isOverload, isStart, isFormError, busIdle, txAllowed, ifsState, overloadCount
  );
endinterface

// File: rtl/inter_frame_space_ctrl.sv
// CAN interframe-space tracker: intermission, suspend transmission and bus idle after every frame,
// with a bounded consecutive-overload budget and SOF / transmit-permission reporting.
module inter_frame_space_ctrl #(
  parameter int INTERMISSION_BITS = 3,
  parameter int SUSPEND_BITS      = 8,
  parameter int MAX_OVERLOADS     = 2
) (
  input logic                    clk,
  input logic                    rst,
  inter_frame_space_ctrl_if.slave ifs
);

  localparam int MAX_BITS = (INTERMISSION_BITS > SUSPEND_BITS) ? INTERMISSION_BITS : SUSPEND_BITS;
  localparam int CNT_W    = $clog2(MAX_BITS + 1);
  localparam int OVL_W    = (MAX_OVERLOADS > 0) ? $clog2(MAX_OVERLOADS + 1) : 1;

  localparam logic [CNT_W-1:0] INT_LAST = CNT_W'(INTERMISSION_BITS - 1);
  localparam logic [CNT_W-1:0] SUS_LAST = CNT_W'(SUSPEND_BITS - 1);
  localparam logic [OVL_W-1:0] OVL_MAX  = OVL_W'(MAX_OVERLOADS);

  typedef enum logic [1:0] {
    WAIT_FRAME   = 2'd0,
    INTERMISSION = 2'd1,
    SUSPEND      = 2'd2,
    BUS_IDLE     = 2'd3
  } ifs_state_e;

  ifs_state_e       state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [OVL_W-1:0] ovl_cnt_q, ovl_cnt_d;
  logic             suspend_req_q, suspend_req_d;
  logic             is_overload_q, is_overload_d;
  logic             is_start_q, is_start_d;
  logic             is_form_error_q, is_form_error_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= BUS_IDLE;
      bit_cnt_q       <= '0;
      ovl_cnt_q       <= '0;
      suspend_req_q   <= 1'b0;
      is_overload_q   <= 1'b0;
      is_start_q      <= 1'b0;
      is_form_error_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      bit_cnt_q       <= bit_cnt_d;
      ovl_cnt_q       <= ovl_cnt_d;
      suspend_req_q   <= suspend_req_d;
      is_overload_q   <= is_overload_d;
      is_start_q      <= is_start_d;
      is_form_error_q <= is_form_error_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    bit_cnt_d       = bit_cnt_q;
    ovl_cnt_d       = ovl_cnt_q;
    suspend_req_d   = suspend_req_q;
    is_overload_d   = 1'b0;
    is_start_d      = 1'b0;
    is_form_error_d = 1'b0;

    if (ifs.samplePoint) begin
      if (ifs.frameEnd) begin
        // A new frame end always restarts intermission, whatever the bus level in this bit.
        state_d       = INTERMISSION;
        bit_cnt_d     = '0;
        suspend_req_d = ifs.errorPassive & ifs.wasTransmitter & ~ifs.endIsOverload;
        if (!ifs.endIsOverload) begin
          ovl_cnt_d = '0;
        end
      end else begin
        unique case (state_q)
          INTERMISSION: begin
            if (ifs.canRX) begin
              if (bit_cnt_q < INT_LAST) begin
                bit_cnt_d = bit_cnt_q + 1'b1;
              end else begin
                state_d   = suspend_req_q ? SUSPEND : BUS_IDLE;
                bit_cnt_d = '0;
              end
            end else if (bit_cnt_q >= INT_LAST) begin
              // Dominant in the last intermission bit is a legal SOF, not an overload.
              is_start_d = 1'b1;
              state_d    = WAIT_FRAME;
              bit_cnt_d  = '0;
            end else if (ovl_cnt_q < OVL_MAX) begin
              is_overload_d = 1'b1;
              ovl_cnt_d     = ovl_cnt_q + 1'b1;
              state_d       = WAIT_FRAME;
              bit_cnt_d     = '0;
            end else begin
              is_form_error_d = 1'b1;
              state_d         = WAIT_FRAME;
              bit_cnt_d       = '0;
            end
          end
          SUSPEND: begin
            if (ifs.canRX) begin
              if (bit_cnt_q >= SUS_LAST) begin
                state_d   = BUS_IDLE;
                bit_cnt_d = '0;
              end else begin
                bit_cnt_d = bit_cnt_q + 1'b1;
              end
            end else begin
              // Another node started a frame while we were suspended: we become receiver.
              is_start_d = 1'b1;
              state_d    = WAIT_FRAME;
              bit_cnt_d  = '0;
            end
          end
          BUS_IDLE: begin
            if (!ifs.canRX) begin
              is_start_d = 1'b1;
              state_d    = WAIT_FRAME;
              bit_cnt_d  = '0;
            end
          end
          WAIT_FRAME: begin
            state_d = WAIT_FRAME;
          end
          default: begin
            state_d   = BUS_IDLE;
            bit_cnt_d = '0;
          end
        endcase
      end
    end
  end

  // Transmit permission opens one bit early so a pending frame can drive SOF right after intermission.
  assign ifs.txAllowed     = (state_q == BUS_IDLE) |
                             ((state_q == INTERMISSION) & (bit_cnt_q == INT_LAST) & ~suspend_req_q);
  assign ifs.busIdle       = (state_q == BUS_IDLE);
  assign ifs.ifsState      = state_q;
  assign ifs.overloadCount = ovl_cnt_q;
  assign ifs.isOverload    = is_overload_q;
  assign ifs.isStart       = is_start_q;
  assign ifs.isFormError   = is_form_error_q;

  a_one_pulse: assert property (@(posedge clk) disable iff (rst)
    $onehot0({is_overload_q, is_start_q, is_form_error_q}));

endmodule

// File: tb/tb_inter_frame_space_ctrl.sv
// Table-driven bench for inter_frame_space_ctrl with a scoreboard queue of expected output words.
module tb_inter_frame_space_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  inter_frame_space_ctrl_if #(.MAX_OVERLOADS(2)) bus ();

  inter_frame_space_ctrl #(
    .INTERMISSION_BITS(3),
    .SUSPEND_BITS(8),
    .MAX_OVERLOADS(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ifs(bus.slave)
  );

  // Expected word: {isOverload, isStart, isFormError, busIdle, txAllowed, ifsState[1:0], overloadCount[1:0]}
  typedef struct {
    logic       sp;
    logic       rx;
    logic       fe;
    logic       eio;
    logic       wt;
    logic       ep;
    logic [8:0] exp;
  } vec_t;

  logic [8:0] exp_q[$];
  vec_t       tbl[$];
  int         n_checks = 0;
  int         n_fail   = 0;

  function automatic logic [8:0] exp_of(input int st, input int cnt, input int tx, input int p);
    logic [1:0] s2;
    s2 = 2'(st);
    return {3'(p), (s2 == 2'd3), 1'(tx), s2, 2'(cnt)};
  endfunction

  function automatic vec_t mk(input int sp, input int rx, input int fe, input int eio, input int wt,
                              input int ep, input int st, input int cnt, input int tx, input int p);
    vec_t v;
    v.sp  = 1'(sp);
    v.rx  = 1'(rx);
    v.fe  = 1'(fe);
    v.eio = 1'(eio);
    v.wt  = 1'(wt);
    v.ep  = 1'(ep);
    v.exp = exp_of(st, cnt, tx, p);
    return v;
  endfunction

  function automatic logic [8:0] observed();
    return {bus.isOverload, bus.isStart, bus.isFormError, bus.busIdle, bus.txAllowed,
            bus.ifsState, bus.overloadCount};
  endfunction

  task automatic drive(input vec_t v);
    bus.samplePoint    = v.sp;
    bus.canRX          = v.rx;
    bus.frameEnd       = v.fe;
    bus.endIsOverload  = v.eio;
    bus.wasTransmitter = v.wt;
    bus.errorPassive   = v.ep;
  endtask

  task automatic check_next(input string name);
    logic [8:0] e;
    logic [8:0] g;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: scoreboard empty, got %b", name, observed());
    end else begin
      e = exp_q.pop_front();
      g = observed();
      if (g !== e) begin
        n_fail++;
        $display("FAIL %s: ov/st/ferr/idle/tx/state/cnt got %b/%b/%b/%b/%b/%0d/%0d expected %b/%b/%b/%b/%b/%0d/%0d",
                 name, g[8], g[7], g[6], g[5], g[4], g[3:2], g[1:0],
                 e[8], e[7], e[6], e[5], e[4], e[3:2], e[1:0]);
      end
    end
  endtask

  task automatic step(input vec_t v, input string name);
    @(negedge clk);
    drive(v);
    exp_q.push_back(v.exp);
    @(posedge clk);
    #1;
    check_next(name);
  endtask

  initial begin
    // Columns: sp rx fe eio wt ep | state cnt tx pulses{ov,st,ferr}
    // Idle bus, then SOF from BUS_IDLE; pulse clears without samplePoint; WAIT_FRAME ignores canRX.
    repeat (5) tbl.push_back(mk(1,1,0,0,0,0, 3,0,1,3'b000));
    tbl.push_back(mk(1,0,0,0,0,0, 0,0,0,3'b010));
    tbl.push_back(mk(0,1,0,0,0,0, 0,0,0,3'b000));
    tbl.push_back(mk(1,0,0,0,0,0, 0,0,0,3'b000));
    // Plain intermission; no samplePoint means nothing moves, even with a dominant level.
    tbl.push_back(mk(1,1,1,0,1,0, 1,0,0,3'b000));
    tbl.push_back(mk(1,1,0,0,0,0, 1,0,0,3'b000));
    tbl.push_back(mk(1,1,0,0,0,0, 1,0,1,3'b000));
    tbl.push_back(mk(0,0,0,0,0,0, 1,0,1,3'b000));
    tbl.push_back(mk(1,1,0,0,0,0, 3,0,1,3'b000));
    // Overload budget: two overloads, then form error; SOF in last bit keeps the count.
    tbl.push_back(mk(1,1,1,0,0,0, 1,0,0,3'b000));
    tbl.push_back(mk(1,1,0,0,0,0, 1,0,0,3'b000));
    tbl.push_back(mk(1,0,0,0,0,0, 0,1,0,3'b100));
    tbl.push_back(mk(1,0,0,0,0,0, 0,1,0,3'b000));
    tbl.push_back(mk(1,1,1,1,0,0, 1,1,0,3'b000));
    tbl.push_back(mk(1,0,0,0,0,0, 0,2,0,3'b100));
    tbl.push_back(mk(1,1,1,1,0,0, 1,2,0,3'b000));
    tbl.push_back(mk(1,0,0,0,0,0, 0,2,0,3'b001));
    tbl.push_back(mk(1,1,1,1,0,0, 1,2,0,3'b000));
    tbl.push_back(mk(1,1,0,0,0,0, 1,2,0,3'b000));
    tbl.push_back(mk(1,1,0,0,0,0, 1,2,1,3'b000));
    tbl.push_back(mk(1,0,0,0,0,0, 0,2,0,3'b010));
    tbl.push_back(mk(1,1,1,0,0,0, 1,0,0,3'b000));
    // Back-to-back frameEnd restarts intermission; frameEnd beats a dominant bit.
    tbl.push_back(mk(1,1,0,0,0,0, 1,0,0,3'b000));
    tbl.push_back(mk(1,0,1,0,0,0, 1,0,0,3'b000));
    tbl.push_back(mk(1,1,1,0,0,0, 1,0,0,3'b000));
    tbl.push_back(mk(1,1,0,0,0,0, 1,0,0,3'b000));
    tbl.push_back(mk(1,1,0,0,0,0, 1,0,1,3'b000));
    tbl.push_back(mk(1,1,0,0,0,0, 3,0,1,3'b000));
    // Error-passive transmitter: full 8-bit suspend, errorPassive dropped after the latch.
    tbl.push_back(mk(1,1,1,0,1,1, 1,0,0,3'b000));
    tbl.push_back(mk(1,1,0,0,0,0, 1,0,0,3'b000));
    tbl.push_back(mk(1,1,0,0,0,0, 1,0,0,3'b000));
    tbl.push_back(mk(1,1,0,0,0,0, 2,0,0,3'b000));
    repeat (7) tbl.push_back(mk(1,1,0,0,0,0, 2,0,0,3'b000));
    tbl.push_back(mk(1,1,0,0,0,0, 3,0,1,3'b000));
    // Suspend broken by a dominant bit on suspend bit 4.
    tbl.push_back(mk(1,1,1,0,1,1, 1,0,0,3'b000));
    tbl.push_back(mk(1,1,0,0,0,0, 1,0,0,3'b000));
    tbl.push_back(mk(1,1,0,0,0,0, 1,0,0,3'b000));
    tbl.push_back(mk(1,1,0,0,0,0, 2,0,0,3'b000));
    repeat (3) tbl.push_back(mk(1,1,0,0,0,0, 2,0,0,3'b000));
    tbl.push_back(mk(1,0,0,0,0,0, 0,0,0,3'b010));
    tbl.push_back(mk(0,1,0,0,0,0, 0,0,0,3'b000));
    // An ended overload frame never requests suspend.
    tbl.push_back(mk(1,1,1,1,1,1, 1,0,0,3'b000));
    tbl.push_back(mk(1,1,0,0,0,0, 1,0,0,3'b000));
    tbl.push_back(mk(1,1,0,0,0,0, 1,0,1,3'b000));
    tbl.push_back(mk(1,1,0,0,0,0, 3,0,1,3'b000));

    rst = 1'b1;
    drive(mk(0,1,0,0,0,0, 3,0,1,0));
    repeat (3) @(posedge clk);
    #1;
    exp_q.push_back(exp_of(3, 0, 1, 0));
    check_next("reset_state");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i], $sformatf("vec%0d", i));
    end

    // Asynchronous reset in the middle of SUSPEND.
    step(mk(1,1,1,0,1,1, 1,0,0,3'b000), "rs_fe");
    step(mk(1,1,0,0,0,0, 1,0,0,3'b000), "rs_i1");
    step(mk(1,1,0,0,0,0, 1,0,0,3'b000), "rs_i2");
    step(mk(1,1,0,0,0,0, 2,0,0,3'b000), "rs_susp");
    step(mk(1,1,0,0,0,0, 2,0,0,3'b000), "rs_s1");
    @(negedge clk);
    drive(mk(0,1,0,0,0,0, 3,0,1,0));
    #2;
    rst = 1'b1;
    #1;
    exp_q.push_back(exp_of(3, 0, 1, 0));
    check_next("rst_async_suspend");
    @(negedge clk);
    rst = 1'b0;
    step(mk(1,1,0,0,0,0, 3,0,1,3'b000), "post_rst_idle");

    // Reset while an overload pulse is high drops the pulse and the count.
    step(mk(1,1,1,0,0,0, 1,0,0,3'b000), "rp_fe");
    step(mk(1,0,0,0,0,0, 0,1,0,3'b100), "rp_ovl");
    #1;
    rst = 1'b1;
    #1;
    exp_q.push_back(exp_of(3, 0, 1, 0));
    check_next("rst_drops_pulse");
    @(negedge clk);
    drive(mk(0,1,0,0,0,0, 3,0,1,0));
    rst = 1'b0;
    step(mk(1,0,0,0,0,0, 0,0,0,3'b010), "post_rst_start");
    step(mk(0,1,0,0,0,0, 0,0,0,3'b000), "post_rst_clear");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
